mul8_seq_ctrl: RTL and testbench



---
 rtl/mul8_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned multiply built from four 4x4 nibble products.
// One shared multiplier_4bit is sequenced by a small FSM into a 16-bit accumulator.

module multiplier_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);

    // Shift-and-add array: one row per multiplier bit.
    always_comb begin
        prod = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                prod = prod + ({4'd0, x} << i);
            end
        end
    end

endmodule

module mul8_seq_ctrl #(
    parameter int PIPE_PP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    localparam bit PIPE = (PIPE_PP != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [7:0]  pp_q, pp_d;
    logic [3:0]  sh_q, sh_d;

    logic [3:0]  nib_x;
    logic [3:0]  nib_y;
    logic [7:0]  pp;
    logic [3:0]  sh_cur;
    logic [15:0] add_term;
    logic [15:0] acc_sum;

    multiplier_4bit u_mul (
        .x    (nib_x),
        .y    (nib_y),
        .prod (pp)
    );

    // Nibble select and shifted partial product for the current step.
    always_comb begin
        nib_x  = step_q[1] ? a_q[7:4] : a_q[3:0];
        nib_y  = step_q[0] ? b_q[7:4] : b_q[3:0];
        sh_cur = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 2'b00};
        if (PIPE) begin
            add_term = {8'd0, pp_q} << sh_q;
        end else begin
            add_term = {8'd0, pp} << sh_cur;
        end
        acc_sum = acc_q + add_term;
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        done_d  = 1'b0;
        pp_d    = pp_q;
        sh_d    = sh_q;
        unique case (state_q)
            S_IDLE: begin
                pp_d = 8'd0;
                sh_d = 4'd0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'd0;
                    step_d  = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (PIPE) begin
                    pp_d = pp;
                    sh_d = sh_cur;
                end
                if (step_q == 2'd3) begin
                    if (PIPE) begin
                        state_d = S_FLUSH;
                    end else begin
                        p_d     = acc_sum;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                acc_d   = acc_sum;
                p_d     = acc_sum;
                done_d  = 1'b1;
                pp_d    = 8'd0;
                sh_d    = 4'd0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            p_q     <= 16'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pp_q    <= 8'd0;
            sh_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pp_q    <= pp_d;
            sh_q    <= sh_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: directed and random checks of both PIPE_PP variants.
// Reference results come from plain a*b and fixed start-to-done latencies.

module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  a0 = 8'd0;
    logic [7:0]  b0 = 8'd0;
    logic [7:0]  a1 = 8'd0;
    logic [7:0]  b1 = 8'd0;
    logic        busy0, done0, busy1, done1;
    logic [15:0] p0, p1;

    int errs = 0;
    int checks = 0;

    localparam int LAT0 = 4;
    localparam int LAT1 = 5;

    mul8_seq_ctrl #(.PIPE_PP(0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .start (start0),
        .a     (a0),
        .b     (b0),
        .busy  (busy0),
        .done  (done0),
        .p     (p0)
    );

    mul8_seq_ctrl #(.PIPE_PP(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .p     (p1)
    );

    always #5 clk = ~clk;

    // Issue one op on the unpipelined DUT; returns at the negedge where done is seen.
    task automatic op0(input logic [7:0] x, input logic [7:0] y,
                       output int lat, output logic [15:0] res,
                       output logic bsy);
        start0 = 1'b1;
        a0 = x;
        b0 = y;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        bsy = busy0;
        lat = 0;
        while (done0 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = p0;
    endtask

    // Same for the pipelined DUT.
    task automatic op1(input logic [7:0] x, input logic [7:0] y,
                       output int lat, output logic [15:0] res,
                       output logic bsy);
        start1 = 1'b1;
        a1 = x;
        b1 = y;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        bsy = busy1;
        lat = 0;
        while (done1 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = p1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_busy0 got=%b exp=0", busy0);
        end
        checks++;
        if (done0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_done0 got=%b exp=0", done0);
        end
        checks++;
        if (p0 !== 16'h0000) begin
            errs++;
            $display("FAIL reset_p0 got=%h exp=0000", p0);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || p1 !== 16'h0000) begin
            errs++;
            $display("FAIL reset_dut1 got busy=%b done=%b p=%h exp 0/0/0000",
                     busy1, done1, p1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] res;
        logic bsy;
        op0(8'hFF, 8'hFF, lat, res, bsy);
        checks++;
        if (bsy !== 1'b1) begin
            errs++;
            $display("FAIL basic_busy_rise got=%b exp=1", bsy);
        end
        checks++;
        if (lat !== LAT0) begin
            errs++;
            $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT0);
        end
        checks++;
        if (res !== 16'hFE01) begin
            errs++;
            $display("FAIL basic_p got=%h exp=fe01", res);
        end
        checks++;
        if (busy0 !== 1'b1) begin
            errs++;
            $display("FAIL basic_busy_in_done got=%b exp=1", busy0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errs++;
            $display("FAIL basic_after_done got done=%b busy=%b exp 0/0",
                     done0, busy0);
        end
        checks++;
        if (p0 !== 16'hFE01) begin
            errs++;
            $display("FAIL basic_p_hold got=%h exp=fe01", p0);
        end
    endtask

    task automatic test_hold_p();
        int lat;
        int bad;
        logic [15:0] res;
        logic bsy;
        @(negedge clk);
        op0(8'h12, 8'h34, lat, res, bsy);
        checks++;
        if (res !== 16'h03A8) begin
            errs++;
            $display("FAIL hold_first_p got=%h exp=03a8", res);
        end
        @(negedge clk);
        start0 = 1'b1;
        a0 = 8'h00;
        b0 = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        lat = 0;
        bad = 0;
        while (done0 !== 1'b1 && lat < 20) begin
            if (p0 !== 16'h03A8) bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL hold_p_busy changed_cycles=%0d exp=0", bad);
        end
        checks++;
        if (lat !== LAT0) begin
            errs++;
            $display("FAIL hold_zero_latency got=%0d exp=%0d", lat, LAT0);
        end
        checks++;
        if (p0 !== 16'h0000) begin
            errs++;
            $display("FAIL hold_zero_p got=%h exp=0000", p0);
        end
    endtask

    task automatic test_busy_ignore();
        int nd;
        int dc;
        logic [15:0] pr;
        nd = 0;
        dc = 0;
        pr = 16'hxxxx;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        a0 = 8'h0F;
        b0 = 8'hF0;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start0 = (c == 2 || c == 4);
            a0 = 8'hFF;
            b0 = 8'hFF;
            if (done0 === 1'b1) begin
                nd++;
                dc = c;
                pr = p0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (nd != 1) begin
            errs++;
            $display("FAIL ignore_done_count got=%0d exp=1", nd);
        end
        checks++;
        if (pr !== 16'h0E10) begin
            errs++;
            $display("FAIL ignore_p got=%h exp=0e10", pr);
        end
        checks++;
        if (dc != LAT0 + 1) begin
            errs++;
            $display("FAIL ignore_done_cycle got=%0d exp=%0d", dc, LAT0 + 1);
        end
    endtask

    task automatic test_rst_mid();
        int nd;
        int lat;
        logic [15:0] res;
        logic bsy;
        @(negedge clk);
        start0 = 1'b1;
        a0 = 8'hAB;
        b0 = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || p0 !== 16'h0000) begin
            errs++;
            $display("FAIL rst_mid got busy=%b done=%b p=%h exp 0/0/0000",
                     busy0, done0, p0);
        end
        rst = 1'b0;
        start0 = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errs++;
            $display("FAIL rst_mid_quiet active_cycles=%0d exp=0", nd);
        end
        op0(8'h03, 8'h05, lat, res, bsy);
        checks++;
        if (res !== 16'h000F || lat !== LAT0) begin
            errs++;
            $display("FAIL rst_mid_next got p=%h lat=%0d exp 000f/%0d",
                     res, lat, LAT0);
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        int d1;
        int d2;
        logic [15:0] r1;
        logic [15:0] r2;
        nd = 0;
        d1 = 0;
        d2 = 0;
        r1 = 16'hxxxx;
        r2 = 16'hxxxx;
        @(negedge clk);
        start0 = 1'b1;
        a0 = 8'h10;
        b0 = 8'h10;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            a0 = 8'h80;
            b0 = 8'h02;
            if (done0 === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    d1 = c;
                    r1 = p0;
                end else begin
                    d2 = c;
                    r2 = p0;
                    start0 = 1'b0;
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (nd != 2) begin
            errs++;
            $display("FAIL b2b_done_count got=%0d exp=2", nd);
        end
        checks++;
        if (r1 !== 16'h0100 || r2 !== 16'h0100) begin
            errs++;
            $display("FAIL b2b_results got=%h,%h exp=0100,0100", r1, r2);
        end
        checks++;
        if (d1 != LAT0 + 1 || d2 - d1 != 6) begin
            errs++;
            $display("FAIL b2b_spacing got d1=%0d gap=%0d exp %0d/6",
                     d1, d2 - d1, LAT0 + 1);
        end
    endtask

    task automatic test_pipe();
        int lat;
        logic [15:0] res;
        logic bsy;
        @(negedge clk);
        op1(8'hFF, 8'h01, lat, res, bsy);
        checks++;
        if (bsy !== 1'b1) begin
            errs++;
            $display("FAIL pipe_busy_rise got=%b exp=1", bsy);
        end
        checks++;
        if (lat !== LAT1) begin
            errs++;
            $display("FAIL pipe_latency got=%0d exp=%0d", lat, LAT1);
        end
        checks++;
        if (res !== 16'h00FF) begin
            errs++;
            $display("FAIL pipe_p got=%h exp=00ff", res);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errs++;
            $display("FAIL pipe_after_done got done=%b busy=%b exp 0/0",
                     done1, busy1);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] res;
        logic [15:0] exp_p;
        logic bsy;
        logic [7:0] x;
        logic [7:0] y;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            if (i % 50 == 0) x = 8'h00;
            if (i % 50 == 1) y = 8'hFF;
            exp_p = 16'(x) * 16'(y);
            @(negedge clk);
            op0(x, y, lat, res, bsy);
            checks++;
            if (res !== exp_p || lat !== LAT0) begin
                errs++;
                $display("FAIL rand0 %h*%h got p=%h lat=%0d exp %h/%0d",
                         x, y, res, lat, exp_p, LAT0);
            end
            @(negedge clk);
            op1(x, y, lat, res, bsy);
            checks++;
            if (res !== exp_p || lat !== LAT1) begin
                errs++;
                $display("FAIL rand1 %h*%h got p=%h lat=%0d exp %h/%0d",
                         x, y, res, lat, exp_p, LAT1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_p();
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        test_pipe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
